// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: grants the CPU one-cycle clock enables, paced by a free-run period or debounced step presses.
// Latency: run switch -> RUN in 3 edges, held step button -> cpu_ce in DB_CYCLES+3 edges; presses arriving in RUN/STEP are dropped.
module cpu_run_ctrl #(
  parameter int DIV_W     = 32,
  parameter int DB_CYCLES = 500000,
  parameter int PC_W      = 32
) (
  input  logic             clk100MHz,
  input  logic             rst_n,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] period,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             halted,
  output logic [15:0]      step_count
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  logic [1:0]       r_run_sync;
  logic [1:0]       r_btn_sync;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_btn_db;
  logic             r_btn_db_d;
  logic [DIV_W-1:0] r_cnt;
  logic             r_run_lock;
  state_t           r_state;
  logic             r_cpu_ce;
  logic             r_halted;
  logic [15:0]      r_step_count;

  logic             w_run_s;
  logic             w_btn_s;
  logic             w_press;
  logic [DIV_W-1:0] w_period_m1;
  logic             w_tick;
  logic             w_bp_hit;
  logic             w_run_en;
  state_t           w_state_nxt;
  logic             w_ce_nxt;
  logic             w_halted_nxt;

  assign w_run_s = r_run_sync[1];
  assign w_btn_s = r_btn_sync[1];
  assign w_press = r_btn_db & ~r_btn_db_d;

  assign w_period_m1 = (period == '0) ? '0 : period - DIV_W'(1);
  assign w_tick      = (r_state == S_RUN) && (r_cnt >= w_period_m1);
  assign w_bp_hit    = bp_en && (pc == bp_addr);
  // After a breakpoint the switch must be cycled low before free-run may resume.
  assign w_run_en    = w_run_s && !r_run_lock;

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_run_sync <= '0;
      r_btn_sync <= '0;
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_run_sync <= {r_run_sync[0], mode_run};
      r_btn_sync <= {r_btn_sync[0], step_btn};
      r_btn_db_d <= r_btn_db;
      if (w_btn_s == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_db <= w_btn_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PAUSE;
      r_cnt        <= '0;
      r_run_lock   <= 1'b0;
      r_cpu_ce     <= 1'b0;
      r_halted     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_ce <= w_ce_nxt;
      r_halted <= w_halted_nxt;
      if ((r_state != S_RUN) || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      if (w_state_nxt == S_BREAK) begin
        r_run_lock <= 1'b1;
      end else if (!w_run_s) begin
        r_run_lock <= 1'b0;
      end
      if (r_cpu_ce) begin
        r_step_count <= r_step_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PAUSE: begin
        if (w_run_en)     w_state_nxt = S_RUN;
        else if (w_press) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        if (!w_run_s)                w_state_nxt = S_PAUSE;
        else if (w_tick && w_bp_hit) w_state_nxt = S_BREAK;
      end
      S_STEP:  w_state_nxt = S_PAUSE;
      S_BREAK: begin
        if (!w_run_s)     w_state_nxt = S_PAUSE;
        else if (w_press) w_state_nxt = S_STEP;
      end
      default: w_state_nxt = S_PAUSE;
    endcase
  end

  always_comb begin
    w_ce_nxt     = 1'b0;
    w_halted_nxt = 1'b0;
    if (w_state_nxt == S_STEP) begin
      w_ce_nxt = 1'b1;
    end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && w_tick) begin
      w_ce_nxt = 1'b1;
    end
    if (w_state_nxt == S_BREAK) begin
      w_halted_nxt = 1'b1;
    end
  end

  assign cpu_ce     = r_cpu_ce;
  assign state      = r_state;
  assign halted     = r_halted;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenario sequence with randomized periods and breakpoints,
// expectations taken from an arithmetic model of pulse spacing and debounce latency.
module tb_cpu_run_ctrl;
  localparam int DIV_W = 32;
  localparam int PC_W  = 32;
  localparam int DB    = 4;

  logic             clk100MHz = 1'b0;
  logic             rst_n     = 1'b0;
  logic             mode_run  = 1'b0;
  logic             step_btn  = 1'b0;
  logic [DIV_W-1:0] period    = 32'd3;
  logic             bp_en     = 1'b0;
  logic [PC_W-1:0]  bp_addr   = '0;
  logic [PC_W-1:0]  pc        = '0;
  logic             cpu_ce;
  logic [1:0]       state;
  logic             halted;
  logic [15:0]      step_count;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;
  bit pc_follow = 1'b0;

  always #5 clk100MHz = ~clk100MHz;

  cpu_run_ctrl #(.DIV_W(DIV_W), .DB_CYCLES(DB), .PC_W(PC_W)) dut (
    .clk100MHz (clk100MHz),
    .rst_n     (rst_n),
    .mode_run  (mode_run),
    .step_btn  (step_btn),
    .period    (period),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .halted    (halted),
    .step_count(step_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the emulated CPU advances its PC on every granted instruction.
  task automatic cyc();
    @(posedge clk100MHz);
    #1;
    if (pc_follow && cpu_ce) pc = pc + 32'd4;
  endtask

  task automatic expect_ce(input string tag, input bit e);
    chk(tag, 32'(cpu_ce), 32'(e));
    if (e) exp_cnt++;
  endtask

  task automatic enter_run();
    mode_run = 1'b1;
    cyc();
    cyc();
    chk("run_latency_early", 32'(state), 32'd0);
    cyc();
    chk("run_latency", 32'(state), 32'd1);
    chk("run_entry_ce", 32'(cpu_ce), 32'd0);
  endtask

  // Free-run for n pulse slots, then drop the switch; two more RUN edges pass the synchroniser.
  task automatic run_drop(input int pe, input int n);
    for (int k = 1; k <= n + 2; k++) begin
      if (k == n + 1) mode_run = 1'b0;
      cyc();
      expect_ce("freerun_ce", (k % pe) == 0);
    end
    cyc();
    chk("drop_state", 32'(state), 32'd0);
    chk("drop_ce", 32'(cpu_ce), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, pe, n, miss;

    // Reset hold
    repeat (5) cyc();
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("idle_state", 32'(state), 32'd0);

    // Randomized free-run periods, including 0 (treated as 1)
    for (int t = 0; t < 5; t++) begin
      p  = (t == 0) ? 3 : $urandom_range(0, 5);
      pe = (p == 0) ? 1 : p;
      n  = $urandom_range(6, 15);
      period = DIV_W'(p);
      enter_run();
      run_drop(pe, n);
      for (int i = 0; i < 4; i++) chk("pause_quiet", 32'(cpu_ce), 32'd0);
      repeat (2) cyc();
      chk("freerun_count", 32'(step_count), exp_cnt & 32'hFFFF);
    end

    // Period lowered mid-count, then to 1; a press in RUN is ignored and not queued
    period = 32'd10;
    enter_run();
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) step_btn = 1'b1;
      cyc();
      expect_ce("slow_ce", 1'b0);
    end
    period = 32'd2;
    cyc(); expect_ce("period_drop_fire", 1'b1);
    cyc(); expect_ce("period2_gap", 1'b0);
    cyc(); expect_ce("period2_fire", 1'b1);
    step_btn = 1'b0;
    period = 32'd1;
    run_drop(1, 12);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("press_not_queued_state", 32'(state), 32'd0);
      chk("press_not_queued_ce", 32'(cpu_ce), 32'd0);
    end
    chk("press_run_count", 32'(step_count), exp_cnt & 32'hFFFF);

    // Bouncy step button, then a long hold
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      cyc(); chk("bounce_ce", 32'(cpu_ce), 32'd0);
      cyc(); chk("bounce_ce", 32'(cpu_ce), 32'd0);
      step_btn = 1'b0;
      cyc(); chk("bounce_ce", 32'(cpu_ce), 32'd0);
      cyc(); chk("bounce_ce", 32'(cpu_ce), 32'd0);
    end
    step_btn = 1'b1;
    for (int k = 1; k <= DB + 2; k++) begin
      cyc();
      chk("step_wait_ce", 32'(cpu_ce), 32'd0);
    end
    cyc();
    chk("step_state", 32'(state), 32'd2);
    expect_ce("step_ce", 1'b1);
    cyc();
    chk("step_return", 32'(state), 32'd0);
    chk("step_ce_fall", 32'(cpu_ce), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("step_hold_ce", 32'(cpu_ce), 32'd0);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("step_release_ce", 32'(cpu_ce), 32'd0);
    end
    chk("step_count", 32'(step_count), exp_cnt & 32'hFFFF);

    // Breakpoint with randomized address and period
    p = $urandom_range(2, 4);
    n = $urandom_range(1, 5);
    pc = '0;
    bp_addr = PC_W'(4 * n);
    bp_en = 1'b1;
    pc_follow = 1'b1;
    period = DIV_W'(p);
    enter_run();
    for (int k = 1; k <= p * (n + 1); k++) begin
      cyc();
      if (k == p * (n + 1)) begin
        chk("break_state", 32'(state), 32'd3);
        chk("break_halted", 32'(halted), 32'd1);
        expect_ce("break_no_ce", 1'b0);
      end else begin
        expect_ce("bp_run_ce", (k % p) == 0);
      end
    end
    chk("break_pc", pc, bp_addr);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("break_hold_state", 32'(state), 32'd3);
      chk("break_hold_ce", 32'(cpu_ce), 32'd0);
    end
    step_btn = 1'b1;
    for (int k = 1; k <= DB + 2; k++) begin
      cyc();
      chk("break_step_wait", 32'(cpu_ce), 32'd0);
    end
    cyc();
    chk("break_step_state", 32'(state), 32'd2);
    chk("break_step_halted", 32'(halted), 32'd0);
    expect_ce("break_step_ce", 1'b1);
    cyc();
    chk("break_step_return", 32'(state), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("no_resume_state", 32'(state), 32'd0);
      chk("no_resume_ce", 32'(cpu_ce), 32'd0);
    end
    step_btn = 1'b0;
    chk("break_step_pc", pc, bp_addr + 32'd4);
    mode_run = 1'b0;
    repeat (4) cyc();
    chk("rearm_state", 32'(state), 32'd0);
    enter_run();
    run_drop(p, 0);
    bp_en = 1'b0;
    pc_follow = 1'b0;
    repeat (2) cyc();
    chk("bp_count", 32'(step_count), exp_cnt & 32'hFFFF);

    // Asynchronous reset in the middle of a pulse
    period = 32'd2;
    enter_run();
    cyc(); expect_ce("prerst_gap", 1'b0);
    cyc(); expect_ce("prerst_ce", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ce", 32'(cpu_ce), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_count", 32'(step_count), 32'd0);
    exp_cnt = 0;
    mode_run = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_state", 32'(state), 32'd0);

    // step_count wrap over 65536 pulses
    period = 32'd1;
    enter_run();
    miss = 0;
    for (int k = 1; k <= 65536; k++) begin
      cyc();
      exp_cnt++;
      if (cpu_ce !== 1'b1) miss++;
    end
    chk("wrap_ce_missing", 32'(miss), 32'd0);
    chk("wrap_pre", 32'(step_count), (exp_cnt - 1) & 32'hFFFF);
    mode_run = 1'b0;
    cyc();
    chk("wrap_zero", 32'(step_count), exp_cnt & 32'hFFFF);
    expect_ce("wrap_tail1", 1'b1);
    cyc();
    expect_ce("wrap_tail2", 1'b1);
    cyc();
    chk("wrap_drop_state", 32'(state), 32'd0);
    chk("wrap_drop_ce", 32'(cpu_ce), 32'd0);
    repeat (2) cyc();
    chk("wrap_final_count", 32'(step_count), exp_cnt & 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
